// File: rtl/seg7_pkg.sv
// Purpose: shared glyph table, blank glyph and scan-state type for the 7-segment scan multiplexer.
// Latency: none (constants and types only).
// Backpressure: none.
package seg7_pkg;

    // Active-low glyph with every segment dark. Bit order is g..a, so bit 0 is segment a.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low hex glyphs, bit order g..a. Element 0 is the rightmost entry, so the list runs F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } scanState_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Purpose: combinational lookup from a hex nibble to its active-low 7-segment glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: nibble = hex digit in; seg = active-low glyph out, bit order g..a.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Purpose: time-multiplexed driver for a 7-segment display, with double-buffered content, leading-zero blanking and blink.
// Latency: outputs are registered and lag the internal scan state by 1 cycle. iEN=0 or reset forces outputs dark at the next edge.
// Backpressure: none. iLOAD is always accepted, and the most recent load is shown from the next frame boundary.
// Ports: iCLK/iRST_N = clock and synchronous active-low reset; iEN = display enable; iLOAD with iVALUE/iDP/iBLINK/iLZB = content load.
//        oSEG/oSEG_DP/oDIG = active-low segment, decimal-point and digit drives; oFRAME = pulse on the first cycle of digit 0's slot.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iEN,
    input  logic                  iLOAD,
    input  logic [4*DIGITS-1:0]   iVALUE,
    input  logic [DIGITS-1:0]     iDP,
    input  logic [DIGITS-1:0]     iBLINK,
    input  logic                  iLZB,
    output logic [6:0]            oSEG,
    output logic                  oSEG_DP,
    output logic [DIGITS-1:0]     oDIG,
    output logic                  oFRAME
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = $clog2(2 * BLINK_FRAMES);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_DEAD = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] BLINK_HALF = FW'(BLINK_FRAMES);

    // With no dead time a slot starts directly in DRIVE.
    localparam scanState_t SLOT_START = (DEAD_CYC == 0) ? DRIVE : DEAD;

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blink;
        logic                lzb;
    } frameData_t;

    scanState_t       state;
    logic [PW-1:0]    presc;
    logic [IW-1:0]    idx;
    logic [FW-1:0]    frameCnt;

    frameData_t       dispData;
    frameData_t       pendData;
    logic             pendFlag;

    frameData_t       loadData;
    logic             running;
    logic             frameEnd;
    logic [3:0]       curNibble;
    logic [6:0]       hexSeg;
    logic [DIGITS-1:0] zeroFromTop;
    logic             lzBlank;
    logic             blinkOff;

    assign loadData = '{value: iVALUE, dp: iDP, blink: iBLINK, lzb: iLZB};
    assign running  = (state != IDLE);
    // Last cycle of the frame. The display buffer may only change here, so a frame never shows two different values.
    assign frameEnd = iEN && running && (presc == PRESC_LAST) && (idx == IDX_LAST);

    //------------------------------------------------------------------
    // Double buffer: loads land in pending and are promoted at frame end.
    // A load on the frame-end cycle goes straight to the display buffer.
    //------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            dispData <= '0;
            pendData <= '0;
            pendFlag <= 1'b0;
        end else if (frameEnd) begin
            if (iLOAD) begin
                dispData <= loadData;
            end else if (pendFlag) begin
                dispData <= pendData;
            end
            pendFlag <= 1'b0;
        end else if (iLOAD) begin
            pendData <= loadData;
            pendFlag <= 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Glyph selection for the digit currently being scanned.
    //------------------------------------------------------------------
    assign curNibble = dispData.value[{idx, 2'b00} +: 4];

    seg7_hex_decode uHexDecode (
        .nibble (curNibble),
        .seg    (hexSeg)
    );

    // Bit k is set when nibble k and every nibble above it are zero.
    always_comb begin
        zeroFromTop = '0;
        for (int k = 0; k < DIGITS; k++) begin
            zeroFromTop[k] = ((dispData.value >> (4 * k)) == '0);
        end
    end

    // Digit 0 is never blanked, so a value of zero still shows a single 0.
    assign lzBlank  = dispData.lzb && (idx != '0) && zeroFromTop[idx];
    assign blinkOff = dispData.blink[idx] && (frameCnt >= BLINK_HALF);

    //------------------------------------------------------------------
    // Scan FSM with registered outputs. Outputs are derived from the current state, which gives the one-cycle lag.
    // The frame counter advances on the edge that starts a new frame, so the first frame after enable uses count 0.
    //------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N || !iEN) begin
            state    <= IDLE;
            presc    <= '0;
            idx      <= '0;
            frameCnt <= '0;
            oSEG     <= SEG_BLANK;
            oSEG_DP  <= 1'b1;
            oDIG     <= '1;
            oFRAME   <= 1'b0;
        end else begin
            oFRAME <= running && (presc == '0) && (idx == '0);
            if (state == DRIVE) begin
                oDIG    <= ~(DIGITS'(1) << idx);
                oSEG    <= (lzBlank || blinkOff) ? SEG_BLANK : hexSeg;
                oSEG_DP <= blinkOff ? 1'b1 : ~dispData.dp[idx];
            end else begin
                oDIG    <= '1;
                oSEG    <= SEG_BLANK;
                oSEG_DP <= 1'b1;
            end

            case (state)
                IDLE: begin
                    presc <= '0;
                    idx   <= '0;
                    state <= SLOT_START;
                end
                default: begin
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                        state <= SLOT_START;
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            frameCnt <= (frameCnt == FRAME_LAST) ? '0 : frameCnt + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                        if ((presc + 1'b1) == PRESC_DEAD) begin
                            state <= DRIVE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int DEAD_CYC     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iEN;
    logic        iLOAD;
    logic [15:0] iVALUE;
    logic [3:0]  iDP;
    logic [3:0]  iBLINK;
    logic        iLZB;
    logic [6:0]  oSEG;
    logic        oSEG_DP;
    logic [3:0]  oDIG;
    logic        oFRAME;

    seg7_scan_mux #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .DEAD_CYC     (DEAD_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iEN     (iEN),
        .iLOAD   (iLOAD),
        .iVALUE  (iVALUE),
        .iDP     (iDP),
        .iBLINK  (iBLINK),
        .iLZB    (iLZB),
        .oSEG    (oSEG),
        .oSEG_DP (oSEG_DP),
        .oDIG    (oDIG),
        .oFRAME  (oFRAME)
    );

    always #5 iCLK = ~iCLK;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    // Hex glyphs, active-low, bit order g..a, indexed by digit value.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model.
    // mT counts cycles since the scan (re)started; the current frame, digit and slot position are derived from it.
    bit          mRun = 1'b0;
    int          mT = 0;
    logic [15:0] mVal = '0;
    logic [3:0]  mDp = '0, mBlink = '0;
    logic        mLzb = 1'b0;
    logic [15:0] pVal = '0;
    logic [3:0]  pDp = '0, pBlink = '0;
    logic        pLzb = 1'b0;
    bit          pValid = 1'b0;

    bit found;
    int c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock. Predict the outputs from the model state and the inputs, advance the model, then compare after the edge.
    task automatic tick();
        logic [6:0] xSeg;
        logic       xDp;
        logic [3:0] xDig;
        logic       xFrame;
        int         pos, d, p;
        bit         blinkOff, lzBlank;
        xSeg = 7'b1111111; xDp = 1'b1; xDig = 4'b1111; xFrame = 1'b0;
        if (iRST_N && iEN && mRun) begin
            pos      = mT % FRAME_LEN;
            d        = pos / SCAN_DIV;
            p        = pos % SCAN_DIV;
            blinkOff = mBlink[d] && (((mT / FRAME_LEN) % (2 * BLINK_FRAMES)) >= BLINK_FRAMES);
            lzBlank  = mLzb && (d > 0) && ((mVal >> (4 * d)) == 16'h0);
            xFrame   = (pos == 0);
            if (p >= DEAD_CYC) begin
                xDig = ~(4'b0001 << d);
                xSeg = (blinkOff || lzBlank) ? 7'b1111111 : glyph[4'(mVal >> (4 * d))];
                xDp  = blinkOff ? 1'b1 : ~mDp[d];
            end
        end
        if (!iRST_N) begin
            mRun = 0; mT = 0;
            mVal = '0; mDp = '0; mBlink = '0; mLzb = 1'b0;
            pVal = '0; pDp = '0; pBlink = '0; pLzb = 1'b0; pValid = 0;
        end else begin
            if (iEN && mRun && (mT % FRAME_LEN) == FRAME_LEN - 1) begin
                if (iLOAD) begin
                    mVal = iVALUE; mDp = iDP; mBlink = iBLINK; mLzb = iLZB;
                end else if (pValid) begin
                    mVal = pVal; mDp = pDp; mBlink = pBlink; mLzb = pLzb;
                end
                pValid = 0;
            end else if (iLOAD) begin
                pVal = iVALUE; pDp = iDP; pBlink = iBLINK; pLzb = iLZB; pValid = 1;
            end
            if (!iEN)       mRun = 0;
            else if (!mRun) begin mRun = 1; mT = 0; end
            else            mT++;
        end
        @(posedge iCLK);
        #1;
        cyc++;
        check("oSEG",    32'(oSEG),    32'(xSeg));
        check("oSEG_DP", 32'(oSEG_DP), 32'(xDp));
        check("oDIG",    32'(oDIG),    32'(xDig));
        check("oFRAME",  32'(oFRAME),  32'(xFrame));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic lzb);
        iVALUE = v; iDP = dp; iBLINK = bl; iLZB = lzb; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
    endtask

    task automatic waitDig(input logic [3:0] pat, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (oDIG === pat) ok = 1;
        end
    endtask

    task automatic waitFrame(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (oFRAME === 1'b1) ok = 1;
        end
    endtask

    initial begin
        iRST_N = 1'b0; iEN = 1'b0; iLOAD = 1'b0;
        iVALUE = '0; iDP = '0; iBLINK = '0; iLZB = 1'b0;

        // Reset state.
        ticks(3);
        check("rst_seg", 32'(oSEG), 32'h7F);
        check("rst_dig", 32'(oDIG), 32'hF);

        // Basic scan of 12A7, with literal glyph checks and the frame period.
        iRST_N = 1'b1; iEN = 1'b1;
        load(16'h12A7, 4'b0000, 4'b0000, 1'b0);
        ticks(36);
        waitDig(4'b1110, found);
        check("wait_dig0", 32'(found), 32'd1);
        check("dig0_seg_7", 32'(oSEG), 32'(7'b1111000));
        waitDig(4'b0111, found);
        check("wait_dig3", 32'(found), 32'd1);
        check("dig3_seg_1", 32'(oSEG), 32'(7'b1111001));
        waitFrame(found);
        check("wait_frame_a", 32'(found), 32'd1);
        c0 = cyc;
        waitFrame(found);
        check("wait_frame_b", 32'(found), 32'd1);
        check("frame_period", 32'(cyc - c0), 32'd32);

        // Leading-zero blanking.
        load(16'h0005, 4'b0000, 4'b0000, 1'b1);
        ticks(40);
        waitDig(4'b0111, found);
        check("lzb_wait3", 32'(found), 32'd1);
        check("lzb_dig3_blank", 32'(oSEG), 32'h7F);
        waitDig(4'b1110, found);
        check("lzb_wait0", 32'(found), 32'd1);
        check("lzb_dig0_5", 32'(oSEG), 32'(7'b0010010));
        load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        ticks(40);
        waitDig(4'b1110, found);
        check("lzb_wait0z", 32'(found), 32'd1);
        check("lzb_dig0_0", 32'(oSEG), 32'(7'b1000000));

        // Two loads in one frame (the last one wins), then a load on the frame-end cycle.
        waitFrame(found);
        check("mid_wait", 32'(found), 32'd1);
        ticks(4);
        load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        ticks(8);
        load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        ticks(45);
        while (mRun && (mT % FRAME_LEN) != FRAME_LEN - 1) tick();
        load(16'h3BC4, 4'b0101, 4'b0000, 1'b0);
        ticks(FRAME_LEN + 4);

        // Blink on digit 0 with its DP lit: two frames on, two frames off, repeating.
        load(16'h8888, 4'b0001, 4'b0001, 1'b0);
        ticks(6 * FRAME_LEN);

        // Disable while in DRIVE, then re-enable.
        while (!(mRun && (mT % SCAN_DIV) == 4)) tick();
        iEN = 1'b0;
        tick();
        check("en_off_dig", 32'(oDIG), 32'hF);
        check("en_off_frame", 32'(oFRAME), 32'd0);
        ticks(3);
        iEN = 1'b1;
        ticks(2);
        check("reen_frame", 32'(oFRAME), 32'd1);
        ticks(20);

        // Reset while in DRIVE, coinciding with a load.
        while (!(mRun && (mT % SCAN_DIV) == 5)) tick();
        iRST_N = 1'b0;
        iLOAD = 1'b1; iVALUE = 16'hFFFF;
        tick();
        iLOAD = 1'b0;
        check("rst_mid_dig", 32'(oDIG), 32'hF);
        check("rst_mid_frame", 32'(oFRAME), 32'd0);
        iRST_N = 1'b1;
        ticks(2);
        check("rst_rel_frame", 32'(oFRAME), 32'd1);
        ticks(40);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            iLOAD  = ($urandom_range(0, 15) == 0);
            iVALUE = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            iDP    = 4'($urandom);
            iBLINK = 4'($urandom);
            iLZB   = 1'($urandom);
            if (iEN && $urandom_range(0, 299) == 0) iEN = 1'b0;
            else if (!iEN && $urandom_range(0, 5) == 0) iEN = 1'b1;
            iRST_N = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, iCLK cycles per digit slot; legal range >= 4.
REQ-003 Parameter DEAD_CYC, default 2, all-off cycles at the start of each slot (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period; legal range >= 1.
REQ-005 iCLK  in  1  single system clock; all logic is on its rising edge.
REQ-006 iRST_N  in  1  reset, synchronous and active-low.
REQ-007 iEN  in  1  display enable; 0 turns all digits off and holds the scan.
REQ-008 iLOAD  in  1  one-cycle strobe; captures iVALUE/iDP/iBLINK/iLZB into the pending register.
REQ-009 iVALUE  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
REQ-010 iDP  in  DIGITS  decimal point request per digit, 1 = lit.
REQ-011 iBLINK  in  DIGITS  blink enable per digit.
REQ-012 iLZB  in  1  leading-zero blanking enable.
REQ-013 oSEG  out  7  segments g..a (bit 0 = a/top, bit 6 = g/middle), active-low, registered.
REQ-014 oSEG_DP  out  1  decimal point, active-low, registered.
REQ-015 oDIG  out  DIGITS  digit select, active-low one-hot or all-ones, registered.
REQ-016 oFRAME  out  1  one-cycle pulse on the first cycle of digit 0's slot.

Function
REQ-017 States: IDLE, DEAD, DRIVE; IDLE when iEN=0; IDLE->DEAD (digit 0, prescaler 0) on iEN=1; DEAD->DRIVE when prescaler reaches DEAD_CYC (direct to DRIVE if DEAD_CYC=0); at prescaler=SCAN_DIV-1 the prescaler resets to 0, the index advances, and the state returns to DEAD.
REQ-018 Prescaler counts 0..SCAN_DIV-1, width clog2(SCAN_DIV); digit index counts 0..DIGITS-1 and wraps to 0, width max(1,clog2(DIGITS)); frame period is exactly DIGITS*SCAN_DIV cycles.
REQ-019 In IDLE and DEAD: oDIG all ones, oSEG 7'b1111111, oSEG_DP 1.
REQ-020 In DRIVE: oDIG bit idx = 0, all others 1; oSEG = hex encoding of display nibble idx; oSEG_DP = ~dp[idx].
REQ-021 Hex encoding, active-low, g..a: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0011000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-022 Outputs lag the internal state by exactly one cycle (registered outputs).
REQ-023 Double-buffering: iLOAD writes the pending register and sets the pending flag; the display register updates only on the last cycle of the frame (idx=DIGITS-1, prescaler=SCAN_DIV-1) when the flag is set, clearing the flag; no mid-frame tearing.
REQ-024 iLOAD coincident with the end-of-frame cycle: the display register takes the iLOAD data directly; the flag stays clear.
REQ-025 Multiple iLOADs within one frame: the last one wins; earlier values are never displayed.
REQ-026 Leading-zero blanking (iLZB latched = 1): digit k>0 is blanked (oSEG 1111111) if nibbles DIGITS-1..k are all zero; digit 0 is never blanked; the DP of a blanked digit is still driven per dp.
REQ-027 Blink: frame counter counts 0..2*BLINK_FRAMES-1 and increments on each oFRAME; off-phase when count >= BLINK_FRAMES; in the off-phase, digits with blink set drive oSEG 1111111 and oSEG_DP 1, while oDIG still scans.
REQ-028 iEN falling in any state: IDLE on the next cycle, prescaler/index/frame counter cleared, display and pending registers kept.

Reset
REQ-029 On iRST_N=0 at a rising edge: state IDLE; prescaler, index, and frame counter 0; display and pending registers 0; pending flag 0; oSEG 1111111; oSEG_DP 1; oDIG all ones; oFRAME 0.
REQ-030 Reset mid-frame takes priority over iLOAD and iEN; with iEN=1 after release, DEAD digit 0 is entered on the first cycle after release.

Structure
REQ-031 Package seg7_pkg holds the 16-entry hex encoding constant, blank pattern 7'b1111111, and the state enum.
REQ-032 Sub-module seg7_hex_decode: combinational nibble->segment lookup from seg7_pkg, instantiated once on the selected nibble.

Verification (DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2, iEN=1)
REQ-033 Load 16'h12A7, iLZB=0: digit-0 DRIVE oDIG=1110 oSEG=1111000; digit-3 DRIVE oDIG=0111 oSEG=1111001; oFRAME period 32 cycles.
REQ-034 Each slot: 2 cycles oDIG=1111 then 6 cycles one-hot; no cycle with two oDIG bits low.
REQ-035 iLZB=1, load 16'h0005: digits 3..1 show 1111111, digit 0 shows 0010010; load 16'h0000: digit 0 shows 1000000.
REQ-036 Mid-frame iLOAD 16'h1111 then 16'h2222 in the same frame: old value until the frame end, then 2222; 1111 never appears; iLOAD on the end-of-frame cycle is visible in the next frame.
REQ-037 iBLINK=4'b0001, iDP=4'b0001: digit 0 segments and DP lit for 2 frames, off for 2 frames, repeating; digits 1..3 unaffected.
REQ-038 iEN=0 mid-DRIVE and iRST_N=0 mid-DRIVE: next cycle oDIG=1111, oFRAME=0; re-enable restarts at digit 0 with oFRAME on the first cycle of the slot.
